vertex_fetch: RTL and testbench
===============================

// Module: vertex_fetch
// PURPOSE
//  Streams the per-frame triangle list from the 224-bit vertex ROM (TestMesh) into PreCalc.
//  Replaces the TestTriangle stub with a prefetching, FIFO-style source.
//  - Restarts at address 0 on every nextFrame.
//  - Hides ROM read latency behind a small prefetch buffer so PreCalc can pop one triangle per cycle.
// PARAMETERS
//  DATA_W    224  width of one triangle record
//  ADDR_W    8    ROM address width
//  TRI_COUNT 16   triangles per frame, 1..2^ADDR_W
//  DEPTH     4    prefetch buffer entries, power of 2, >=2
//  ROM_LAT   1    cycles from ROM address sample edge to rom_data valid
// PORTS
//  clk100                        in   1       system clock, 100 MHz
//  rst                           in   1       synchronous reset, active-high
//  nextFrame                     in   1       1-cycle pulse: start of frame, restart fetch
//  index                         out  ADDR_W  registered ROM address
//  rom_data                      in   DATA_W  ROM output, valid ROM_LAT cycles after index is sampled
//  VertexBuffer_PreCalc_ReadData out  DATA_W  head-of-buffer triangle (first-word fall-through)
//  VertexBuffer_PreCalc_pop      in   1       consume head entry
//  VertexBuffer_PreCalc_empty    out  1       no valid head entry
//  frame_done                    out  1       all TRI_COUNT triangles consumed this frame
// BEHAVIOUR
//  Reset values
//  - index=0, empty=1, ReadData=0, frame_done=0, state=IDLE.
//  - Buffer occupancy, in-flight count and issue/pop counters all 0.
//  States
//  - IDLE: no reads issued. Leave on nextFrame -> FETCH.
//  - FETCH: issue a read when occ + inflight < DEPTH.
//    - Issue = drive index=issued_cnt this cycle, then issued_cnt+1.
//    - Issued read tags a ROM_LAT-deep valid shift line.
//    - Tag exit writes rom_data into the buffer tail.
//    - Last read issued (issued_cnt = TRI_COUNT-1) -> DRAIN.
//  - DRAIN: no new reads. When pop_cnt reaches TRI_COUNT -> DONE.
//  - DONE: frame_done=1, empty=1. Hold until nextFrame -> FETCH.
//  Credit rule
//  - Credit uses registered occ/inflight only; a same-cycle pop does not grant credit.
//  - Buffer can therefore never overflow.
//  - DEPTH=4, ROM_LAT=1 must sustain one pop per cycle once primed.
//  Latency
//  - nextFrame high in cycle 0 -> index=0 in cycle 1 -> rom_data valid in cycle 2.
//  - empty=0 and ReadData=triangle 0 in cycle 3.
//  Pop
//  - pop while empty=0: head advances at the clock edge; next entry (if any) visible next cycle.
//  - pop while empty=1: ignored. Counters unchanged; no underflow.
//  Pointers
//  - Buffer pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  - occ is log2(DEPTH)+1 bits.
//  Frame restart
//  - nextFrame in any state, including mid-FETCH/DRAIN: flush buffer, kill in-flight tags.
//  - Then zero the counters, index=0, frame_done=0, empty=1, enter FETCH.
//  - Stale ROM data from killed tags is never written.
//  Simultaneous events
//  - rst has priority over nextFrame.
//  - nextFrame has priority over pop; the same-cycle pop is discarded.
//  - Capture and pop in the same cycle: occ unchanged, both pointers advance.
//  Boundaries
//  - TRI_COUNT=1: FETCH issues one read, then DRAIN directly.
//  - TRI_COUNT < DEPTH: all reads are issued before the first pop.
//  - index never exceeds TRI_COUNT-1.
// TESTING
//  - Reset, then idle 10 cycles -> empty=1, index=0, no reads issued, frame_done=0.
//  - nextFrame at cycle 0, pop held high, TRI_COUNT=16 -> ReadData = ROM[0..15] in order,
//    one per cycle from cycle 3. frame_done=1 at cycle 19. empty stays 1 afterwards.
//  - Pop only on every 3rd cycle -> occ never >4.
//    - index stalls while the buffer is full.
//    - All 16 records arrive in order with no duplicates or drops.
//  - nextFrame after 5 pops, with 3 entries buffered and 1 in flight -> empty=1 next cycle.
//    - Next head is ROM[0], not ROM[5] or the stale in-flight data.
//  - Pop asserted while empty=1 (before first data, and in DONE) -> pop_cnt is unchanged.
//    - A later frame still delivers exactly 16 records.
//  - rst and nextFrame asserted together -> state IDLE, nothing fetched until the next nextFrame.

Source files
------------

// File: rtl/vertex_fetch_if.sv
// ---------------------------------------------------------------------------
// vertex_fetch_if
// Vertex buffer read port between vertex_fetch (master, the source) and
// PreCalc (slave, the consumer). The buffer is first-word fall-through.
//   VertexBuffer_PreCalc_ReadData  master->slave  head-of-buffer triangle
//   VertexBuffer_PreCalc_empty     master->slave  no valid head entry
//   VertexBuffer_PreCalc_pop       slave->master  consume the head entry
// ---------------------------------------------------------------------------
interface vertex_fetch_if #(
   parameter int DATA_W = 224
);
   logic [DATA_W-1:0] VertexBuffer_PreCalc_ReadData;
   logic              VertexBuffer_PreCalc_empty;
   logic              VertexBuffer_PreCalc_pop;

   modport master (
      output VertexBuffer_PreCalc_ReadData,
      output VertexBuffer_PreCalc_empty,
      input  VertexBuffer_PreCalc_pop
   );

   modport slave (
      input  VertexBuffer_PreCalc_ReadData,
      input  VertexBuffer_PreCalc_empty,
      output VertexBuffer_PreCalc_pop
   );
endinterface

// File: rtl/vertex_fetch.sv
// ---------------------------------------------------------------------------
// vertex_fetch
// Streams the per-frame triangle list from the vertex ROM into PreCalc
// through a small prefetch buffer that hides the ROM read latency.
// Every nextFrame pulse restarts the fetch at address 0.
// Ports:
//   clk100      in   system clock
//   rst         in   synchronous reset, active-high
//   nextFrame   in   1-cycle pulse: flush and restart fetch at address 0
//   index       out  registered ROM address
//   rom_data    in   ROM output, valid ROM_LAT cycles after index is sampled
//   vb          --   vertex buffer read port (master side)
//   frame_done  out  all TRI_COUNT triangles consumed this frame
// ---------------------------------------------------------------------------
module vertex_fetch #(
   parameter int DATA_W    = 224,
   parameter int ADDR_W    = 8,
   parameter int TRI_COUNT = 16,
   parameter int DEPTH     = 4,
   parameter int ROM_LAT   = 1
) (
   input  logic              clk100,
   input  logic              rst,
   input  logic              nextFrame,
   output logic [ADDR_W-1:0] index,
   input  logic [DATA_W-1:0] rom_data,
   vertex_fetch_if.master    vb,
   output logic              frame_done
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam int FLT_W = $clog2(ROM_LAT + 1);
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TRI_COUNT - 1);
   localparam logic [CNT_W-1:0]  LAST_POP = CNT_W'(TRI_COUNT - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t state, stateNext;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]   wrPtr, rdPtr;
   logic [OCC_W-1:0]   occ;
   logic [FLT_W-1:0]   inflight;
   logic [ROM_LAT-1:0] tagLine;
   logic [CNT_W-1:0]   popCnt;
   logic               issue, capture, popOk, empty, credit;

   assign empty   = (occ == '0);
   assign capture = tagLine[ROM_LAT-1];
   // A pop in a restart cycle is discarded along with the old frame.
   assign popOk   = vb.VertexBuffer_PreCalc_pop && !empty && !nextFrame;
   // Credit looks only at registered occupancy, so a same-cycle pop never
   // lets a read through and the buffer cannot overflow.
   assign credit  = (int'(occ) + int'(inflight)) < DEPTH;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      stateNext = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
         end
         FETCH: begin
            if (credit) begin
               issue = 1'b1;
               if (index == LAST_IDX) stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if (popOk && popCnt == LAST_POP) stateNext = DONE;
         end
         DONE: begin
         end
         default: stateNext = IDLE;
      endcase
      if (nextFrame) begin
         stateNext = FETCH;
         issue     = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk100) begin
      if (rst) begin
         state    <= IDLE;
         index    <= '0;
         wrPtr    <= '0;
         rdPtr    <= '0;
         occ      <= '0;
         inflight <= '0;
         tagLine  <= '0;
         popCnt   <= '0;
      end else begin
         state <= stateNext;
         if (nextFrame) begin
            // Killing the tags guarantees stale ROM data is never captured.
            index    <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            occ      <= '0;
            inflight <= '0;
            tagLine  <= '0;
            popCnt   <= '0;
         end else begin
            tagLine  <= (tagLine << 1) | ROM_LAT'(issue);
            inflight <= inflight + FLT_W'(issue) - FLT_W'(capture);
            occ      <= occ + OCC_W'(capture) - OCC_W'(popOk);
            // index doubles as the issue counter; it parks on the last
            // address instead of running past the end of the mesh.
            if (issue && index != LAST_IDX) index <= index + ADDR_W'(1);
            if (capture) wrPtr <= wrPtr + PTR_W'(1);
            if (popOk) begin
               rdPtr  <= rdPtr + PTR_W'(1);
               popCnt <= popCnt + CNT_W'(1);
            end
         end
      end
   end

   // NOTE: the storage array has no reset; occ gates visibility, so stale
   // contents are never presented.
   always_ff @(posedge clk100) begin
      if (capture && !nextFrame && !rst) mem[wrPtr] <= rom_data;
   end

   assign vb.VertexBuffer_PreCalc_ReadData = empty ? '0 : mem[rdPtr];
   assign vb.VertexBuffer_PreCalc_empty    = empty;
   assign frame_done                       = (state == DONE);
endmodule

// File: tb/tb_vertex_fetch.sv
// ---------------------------------------------------------------------------
// tb_vertex_fetch
// Directed bench for vertex_fetch with a 1-cycle ROM model. A stream-level
// model (records consumed so far, frame active) is checked every cycle on
// the falling edge; directed literal checks pin the latency and ordering.
// ---------------------------------------------------------------------------
module tb_vertex_fetch;
   localparam int DATA_W = 224;
   localparam int ADDR_W = 8;
   localparam int TRI    = 16;
   localparam int DEPTH  = 4;

   localparam logic [DATA_W-1:0] LIT0  = {7{32'hC0DE00FF}};
   localparam logic [DATA_W-1:0] LIT5  = {7{32'hC0DE05FA}};
   localparam logic [DATA_W-1:0] LIT15 = {7{32'hC0DE0FF0}};

   logic              clk100 = 1'b0;
   logic              rst = 1'b1;
   logic              nextFrame = 1'b0;
   logic [ADDR_W-1:0] index;
   logic [DATA_W-1:0] rom_data;
   logic              frame_done;

   vertex_fetch_if #(.DATA_W(DATA_W)) vb ();

   vertex_fetch #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TRI_COUNT(TRI), .DEPTH(DEPTH), .ROM_LAT(1)
   ) dut (
      .clk100(clk100), .rst(rst), .nextFrame(nextFrame), .index(index),
      .rom_data(rom_data), .vb(vb), .frame_done(frame_done)
   );

   always #5 clk100 = ~clk100;

   int checks = 0;
   int errors = 0;

   function automatic logic [DATA_W-1:0] romWord(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {7{16'hC0DE, b, ~b}};
   endfunction

   // ROM: data for the address sampled at an edge is valid the next cycle.
   always @(posedge clk100) rom_data <= romWord(int'(index));

   task automatic check(input bit ok, input string name,
                        input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stream-level model state, describing the current cycle.
   bit modelValid = 0;
   bit inFrame    = 0;
   bit restarted  = 0;
   int popped     = 0;
   bit stallSeen  = 0;
   logic [ADDR_W-1:0] prevIndex = '0;

   always @(negedge clk100) begin
      if (modelValid) begin
         if (!vb.VertexBuffer_PreCalc_empty) begin
            check(popped < TRI, "extra_record", DATA_W'(popped), DATA_W'(TRI - 1));
            check(vb.VertexBuffer_PreCalc_ReadData == romWord(popped), "head_data",
                  vb.VertexBuffer_PreCalc_ReadData, romWord(popped));
         end
         check(frame_done == (inFrame && popped == TRI), "frame_done",
               DATA_W'(frame_done), DATA_W'(inFrame && popped == TRI));
         if (!inFrame || restarted || popped == TRI)
            check(vb.VertexBuffer_PreCalc_empty == 1'b1, "must_be_empty",
                  DATA_W'(vb.VertexBuffer_PreCalc_empty), DATA_W'(1));
         if (!inFrame)
            check(index == '0, "idle_index", DATA_W'(index), DATA_W'(0));
         check(int'(index) <= TRI - 1, "index_range", DATA_W'(index), DATA_W'(TRI - 1));
         // Reads issued never run more than DEPTH ahead of consumption.
         if (inFrame && int'(index) < TRI - 1)
            check(int'(index) <= popped + DEPTH, "occupancy_bound",
                  DATA_W'(index), DATA_W'(popped + DEPTH));
         if (inFrame && !restarted && int'(index) < TRI - 1 && index == prevIndex)
            stallSeen = 1;
      end
      prevIndex = index;
      if (rst) begin
         modelValid = 1;
         inFrame    = 0;
         restarted  = 0;
         popped     = 0;
      end else if (nextFrame) begin
         inFrame   = 1;
         restarted = 1;
         popped    = 0;
      end else begin
         restarted = 0;
         if (vb.VertexBuffer_PreCalc_pop && !vb.VertexBuffer_PreCalc_empty) popped++;
      end
   end

   task automatic step();
      @(posedge clk100);
      #1;
   endtask

   task automatic waitDone(input int budget, input string name);
      for (int c = 0; c < budget && !frame_done; c++) step();
      check(frame_done == 1'b1, name, DATA_W'(frame_done), DATA_W'(1));
      step();
      check(popped == TRI, {name, "_count"}, DATA_W'(popped), DATA_W'(TRI));
   endtask

   initial begin
      vb.VertexBuffer_PreCalc_pop = 1'b0;

      // Reset, then idle.
      step(); step();
      rst = 1'b0;
      repeat (10) step();
      check(index == '0, "idle10_index", DATA_W'(index), DATA_W'(0));
      check(vb.VertexBuffer_PreCalc_empty == 1'b1, "idle10_empty",
            DATA_W'(vb.VertexBuffer_PreCalc_empty), DATA_W'(1));
      check(frame_done == 1'b0, "idle10_done", DATA_W'(frame_done), DATA_W'(0));

      // Full-rate frame with pop held high throughout.
      vb.VertexBuffer_PreCalc_pop = 1'b1;
      nextFrame = 1'b1;
      step();
      nextFrame = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         if (c == 1 || c == 2)
            check(vb.VertexBuffer_PreCalc_empty == 1'b1, "lat_empty",
                  DATA_W'(vb.VertexBuffer_PreCalc_empty), DATA_W'(1));
         if (c == 3) begin
            check(vb.VertexBuffer_PreCalc_empty == 1'b0, "lat_first_valid",
                  DATA_W'(vb.VertexBuffer_PreCalc_empty), DATA_W'(0));
            check(vb.VertexBuffer_PreCalc_ReadData == LIT0, "lat_first_data",
                  vb.VertexBuffer_PreCalc_ReadData, LIT0);
         end
         if (c == 18) begin
            check(vb.VertexBuffer_PreCalc_ReadData == LIT15, "last_data",
                  vb.VertexBuffer_PreCalc_ReadData, LIT15);
            check(frame_done == 1'b0, "done_early", DATA_W'(frame_done), DATA_W'(0));
         end
         if (c == 19)
            check(frame_done == 1'b1, "done_cycle19", DATA_W'(frame_done), DATA_W'(1));
         if (c == 25)
            check(vb.VertexBuffer_PreCalc_empty && frame_done, "done_hold",
                  DATA_W'({vb.VertexBuffer_PreCalc_empty, frame_done}), DATA_W'(3));
         step();
      end
      check(popped == TRI, "fullrate_count", DATA_W'(popped), DATA_W'(TRI));

      // Paced consumer: pop on every third cycle.
      vb.VertexBuffer_PreCalc_pop = 1'b0;
      stallSeen = 0;
      nextFrame = 1'b1;
      step();
      nextFrame = 1'b0;
      for (int c = 1; c < 300 && !frame_done; c++) begin
         vb.VertexBuffer_PreCalc_pop = (c % 3 == 0);
         step();
      end
      vb.VertexBuffer_PreCalc_pop = 1'b0;
      waitDone(10, "paced_done");
      check(stallSeen, "paced_index_stall", DATA_W'(stallSeen), DATA_W'(1));

      // Restart mid-frame: 5 pops, 3 buffered, 1 in flight.
      nextFrame = 1'b1;
      step();
      nextFrame = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         vb.VertexBuffer_PreCalc_pop = (c >= 3 && c <= 7);
         step();
      end
      check(index == ADDR_W'(9), "restart_pre_index", DATA_W'(index), DATA_W'(9));
      check(vb.VertexBuffer_PreCalc_ReadData == LIT5, "restart_pre_head",
            vb.VertexBuffer_PreCalc_ReadData, LIT5);
      nextFrame = 1'b1;
      vb.VertexBuffer_PreCalc_pop = 1'b1;
      step();
      nextFrame = 1'b0;
      check(vb.VertexBuffer_PreCalc_empty == 1'b1, "restart_flush",
            DATA_W'(vb.VertexBuffer_PreCalc_empty), DATA_W'(1));
      step(); step();
      check(vb.VertexBuffer_PreCalc_ReadData == LIT0, "restart_head",
            vb.VertexBuffer_PreCalc_ReadData, LIT0);
      waitDone(40, "restart_done");

      // Reset together with nextFrame: reset wins, nothing is fetched.
      rst = 1'b1;
      nextFrame = 1'b1;
      step();
      rst = 1'b0;
      nextFrame = 1'b0;
      repeat (8) step();
      check(index == '0 && vb.VertexBuffer_PreCalc_empty && !frame_done, "rst_wins",
            DATA_W'({index, vb.VertexBuffer_PreCalc_empty, frame_done}), DATA_W'(2));
      nextFrame = 1'b1;
      step();
      nextFrame = 1'b0;
      waitDone(40, "after_rst_done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
